// File: rtl/vx_perf_pkg.sv
// Shared types and defaults for the memory-system performance counter engine.
package vx_perf_pkg;

  localparam int PERF_CTR_BITS = 44;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_e;

  typedef enum logic [1:0] {
    CH_ICACHE = 2'd0,
    CH_DCACHE = 2'd1,
    CH_SMEM   = 2'd2,
    CH_MEM    = 2'd3
  } perf_chan_e;

endpackage

// File: rtl/vx_perf_acc.sv
// Single perf accumulator: adds a zero-extended increment when enabled, with
// sticky carry-out flag; SATURATE selects wrap or clamp at all-ones.
module vx_perf_acc
  import vx_perf_pkg::*;
#(
  parameter int CTR_BITS = PERF_CTR_BITS,
  parameter int INC_BITS = 4,
  parameter int SATURATE = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [INC_BITS-1:0] inc,
  output logic [CTR_BITS-1:0] count,
  output logic                ovf
);

  logic [CTR_BITS-1:0] r_count;
  logic                r_ovf;
  logic [CTR_BITS:0]   w_sum;
  logic [CTR_BITS-1:0] w_next;

  assign w_sum = {1'b0, r_count} + {{(CTR_BITS + 1 - INC_BITS){1'b0}}, inc};

  always_comb begin
    w_next = w_sum[CTR_BITS-1:0];
    if ((SATURATE != 0) && w_sum[CTR_BITS]) begin
      w_next = '1;
    end
  end

  // clear wins over a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (enable) begin
      r_count <= w_next;
      if (w_sum[CTR_BITS]) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: rtl/vx_perf_memsys_ctrs.sv
// Multi-channel memory-system perf counters: per-channel event and latency
// accumulators, live outstanding-request tracking and a held snapshot port.
module vx_perf_memsys_ctrs
  import vx_perf_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CTR_BITS     = PERF_CTR_BITS,
  parameter int INC_BITS     = 4,
  parameter int PEND_BITS    = 8,
  parameter int SATURATE     = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              clear,
  input  logic [NUM_CHANNELS*INC_BITS-1:0]  evt_inc,
  input  logic [NUM_CHANNELS-1:0]           req_fire,
  input  logic [NUM_CHANNELS-1:0]           rsp_fire,
  input  logic                              snap_req,
  output logic                              snap_valid,
  input  logic                              snap_ready,
  output logic [NUM_CHANNELS*CTR_BITS-1:0]  snap_evt,
  output logic [NUM_CHANNELS*CTR_BITS-1:0]  snap_lat,
  output logic [NUM_CHANNELS*PEND_BITS-1:0] pending,
  output logic [NUM_CHANNELS-1:0]           overflow
);

  logic [NUM_CHANNELS*CTR_BITS-1:0] w_evt_cnt;
  logic [NUM_CHANNELS*CTR_BITS-1:0] w_lat_cnt;
  logic [NUM_CHANNELS-1:0]          w_evt_ovf;
  logic [NUM_CHANNELS-1:0]          w_lat_ovf;

  snap_state_e                      r_state;
  logic                             r_snap_valid;
  logic [NUM_CHANNELS*CTR_BITS-1:0] r_snap_evt;
  logic [NUM_CHANNELS*CTR_BITS-1:0] r_snap_lat;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic [PEND_BITS-1:0] r_pend;

    // Pending tracks requests even while counting is disabled or cleared
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_pend <= '0;
      end else begin
        assert (!(rsp_fire[c] && !req_fire[c] && (r_pend == '0)))
          else $warning("vx_perf_memsys_ctrs: rsp_fire on channel %0d with no outstanding request", c);
        assert (!(req_fire[c] && !rsp_fire[c] && (r_pend == '1)))
          else $warning("vx_perf_memsys_ctrs: req_fire on channel %0d with pending counter full", c);
        if (req_fire[c] && !rsp_fire[c]) begin
          if (r_pend != '1) begin
            r_pend <= r_pend + PEND_BITS'(1);
          end
        end else if (rsp_fire[c] && !req_fire[c]) begin
          if (r_pend != '0) begin
            r_pend <= r_pend - PEND_BITS'(1);
          end
        end
      end
    end

    assign pending[c*PEND_BITS +: PEND_BITS] = r_pend;

    vx_perf_acc #(
      .CTR_BITS (CTR_BITS),
      .INC_BITS (INC_BITS),
      .SATURATE (SATURATE)
    ) u_evt_acc (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (clear),
      .inc    (evt_inc[c*INC_BITS +: INC_BITS]),
      .count  (w_evt_cnt[c*CTR_BITS +: CTR_BITS]),
      .ovf    (w_evt_ovf[c])
    );

    // Latency integrates the pending count as it stood before this cycle's update
    vx_perf_acc #(
      .CTR_BITS (CTR_BITS),
      .INC_BITS (PEND_BITS),
      .SATURATE (SATURATE)
    ) u_lat_acc (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .clear  (clear),
      .inc    (r_pend),
      .count  (w_lat_cnt[c*CTR_BITS +: CTR_BITS]),
      .ovf    (w_lat_ovf[c])
    );
  end

  assign overflow = w_evt_ovf | w_lat_ovf;

  // Capture takes the registered counters, so a same-cycle clear is not seen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_snap_valid <= 1'b0;
      r_snap_evt   <= '0;
      r_snap_lat   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (snap_req) begin
            r_snap_evt   <= w_evt_cnt;
            r_snap_lat   <= w_lat_cnt;
            r_snap_valid <= 1'b1;
            r_state      <= HOLD;
          end
        end
        HOLD: begin
          if (snap_ready) begin
            r_snap_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_snap_valid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign snap_valid = r_snap_valid;
  assign snap_evt   = r_snap_evt;
  assign snap_lat   = r_snap_lat;

endmodule

// File: tb/tb_vx_perf_memsys_ctrs.sv
// Directed bench for vx_perf_memsys_ctrs: a default-width instance plus two
// 8-bit instances (wrap and saturate) for the counter boundary behaviour.
module tb_vx_perf_memsys_ctrs;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable, clear, snap_req, snap_ready;
  logic [15:0]  evt_inc;
  logic [3:0]   req_fire, rsp_fire;
  logic         snap_valid;
  logic [175:0] snap_evt, snap_lat;
  logic [31:0]  pending;
  logic [3:0]   overflow;

  logic         enable8, clear8, snap_req8, snap_ready8;
  logic [15:0]  evt8;
  logic [3:0]   req8, rsp8;
  logic         valid_w, valid_s;
  logic [31:0]  evt_w, evt_s, lat_w, lat_s, pend_w, pend_s;
  logic [3:0]   ovf_w, ovf_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vx_perf_memsys_ctrs u_dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .evt_inc(evt_inc), .req_fire(req_fire), .rsp_fire(rsp_fire),
    .snap_req(snap_req), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .snap_evt(snap_evt), .snap_lat(snap_lat), .pending(pending), .overflow(overflow)
  );

  vx_perf_memsys_ctrs #(.CTR_BITS(8), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable8), .clear(clear8),
    .evt_inc(evt8), .req_fire(req8), .rsp_fire(rsp8),
    .snap_req(snap_req8), .snap_valid(valid_w), .snap_ready(snap_ready8),
    .snap_evt(evt_w), .snap_lat(lat_w), .pending(pend_w), .overflow(ovf_w)
  );

  vx_perf_memsys_ctrs #(.CTR_BITS(8), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable8), .clear(clear8),
    .evt_inc(evt8), .req_fire(req8), .rsp_fire(rsp8),
    .snap_req(snap_req8), .snap_valid(valid_s), .snap_ready(snap_ready8),
    .snap_evt(evt_s), .snap_lat(lat_s), .pending(pend_s), .overflow(ovf_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ch44(input logic [175:0] v, input int c);
    return 64'(v[c*44 +: 44]);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap_take();
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
    check("snap_valid_set", 64'(snap_valid), 64'd1);
  endtask

  task automatic snap_release();
    snap_ready = 1'b1;
    step(1);
    snap_ready = 1'b0;
    check("snap_valid_drop", 64'(snap_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
    evt_inc = '0; req_fire = '0; rsp_fire = '0;
    enable8 = 1'b0; clear8 = 1'b0; snap_req8 = 1'b0; snap_ready8 = 1'b0;
    evt8 = '0; req8 = '0; rsp8 = '0;

    // Reset held three cycles
    step(3);
    check("rst_valid", 64'(snap_valid), 64'd0);
    check("rst_snap_evt", 64'(snap_evt[63:0] | snap_evt[127:64] | 64'(snap_evt[175:128])), 64'd0);
    check("rst_snap_lat", 64'(snap_lat[63:0] | snap_lat[127:64] | 64'(snap_lat[175:128])), 64'd0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_valid8", 64'({valid_w, valid_s}), 64'd0);
    reset = 1'b0;

    // Idle with counting enabled
    enable = 1'b1;
    step(10);
    snap_take();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("idle_evt%0d", i), ch44(snap_evt, i), 64'd0);
      check($sformatf("idle_lat%0d", i), ch44(snap_lat, i), 64'd0);
    end
    snap_release();

    // Events: ch0 += 3 for five cycles, ch2 += 15 once
    evt_inc = 16'h0F03;
    step(1);
    evt_inc = 16'h0003;
    step(4);
    evt_inc = '0;
    snap_take();
    check("evt_ch0", ch44(snap_evt, 0), 64'd15);
    check("evt_ch1", ch44(snap_evt, 1), 64'd0);
    check("evt_ch2", ch44(snap_evt, 2), 64'd15);
    check("evt_ch3", ch44(snap_evt, 3), 64'd0);
    snap_release();

    // Latency on ch1: pending over cycles c1..c5 is 1,2,2,1,1
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    req_fire = 4'b0010; step(1);
    req_fire = 4'b0010; step(1);
    req_fire = 4'b0000;
    check("pend_peak", 64'(pending), 64'h0000_0200);
    step(1);
    rsp_fire = 4'b0010; step(1);
    rsp_fire = 4'b0000;
    check("pend_one", 64'(pending), 64'h0000_0100);
    step(1);
    rsp_fire = 4'b0010; step(1);
    rsp_fire = 4'b0000;
    check("pend_zero", 64'(pending), 64'd0);
    snap_take();
    check("lat_ch1", ch44(snap_lat, 1), 64'd7);
    check("lat_ch0", ch44(snap_lat, 0), 64'd0);
    check("evt_cleared_ch0", ch44(snap_evt, 0), 64'd0);
    check("no_overflow", 64'(overflow), 64'd0);
    snap_release();

    // Pending corner cases
    req_fire = 4'b0001; step(1);
    rsp_fire = 4'b0001; step(1);
    check("pend_req_rsp_same", 64'(pending), 64'd1);
    req_fire = 4'b0000; step(1);
    check("pend_rsp_to_zero", 64'(pending), 64'd0);
    step(1);
    rsp_fire = 4'b0000;
    check("pend_rsp_at_zero", 64'(pending), 64'd0);
    req_fire = 4'b0100;
    step(255);
    check("pend_full", 64'(pending), 64'h00FF_0000);
    step(1);
    req_fire = 4'b0000;
    check("pend_full_hold", 64'(pending), 64'h00FF_0000);
    rsp_fire = 4'b0100;
    step(255);
    rsp_fire = 4'b0000;
    check("pend_drained", 64'(pending), 64'd0);

    // Snapshot with same-cycle clear, held while snap_ready is low
    evt_inc = 16'h5000;
    step(1);
    evt_inc = '0;
    snap_req = 1'b1; clear = 1'b1;
    step(1);
    snap_req = 1'b0; clear = 1'b0;
    check("hold_valid", 64'(snap_valid), 64'd1);
    check("hold_evt_ch3", ch44(snap_evt, 3), 64'd5);
    check("hold_lat_ch1", ch44(snap_lat, 1), 64'd7);
    for (int i = 0; i < 4; i++) begin
      snap_req = (i == 1);
      step(1);
      snap_req = 1'b0;
      check($sformatf("hold_stable_valid%0d", i), 64'(snap_valid), 64'd1);
      check($sformatf("hold_stable_evt%0d", i), ch44(snap_evt, 3), 64'd5);
    end
    snap_ready = 1'b1; snap_req = 1'b1;
    step(1);
    snap_ready = 1'b0;
    check("req_on_release_ignored", 64'(snap_valid), 64'd0);
    step(1);
    snap_req = 1'b0;
    check("second_snap_valid", 64'(snap_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post_clear_evt%0d", i), ch44(snap_evt, i), 64'd0);
      check($sformatf("post_clear_lat%0d", i), ch44(snap_lat, i), 64'd0);
    end
    snap_release();

    // Reset arriving while a snapshot is held
    evt_inc = 16'h0020;
    step(1);
    evt_inc = '0;
    snap_take();
    check("pre_reset_evt_ch1", ch44(snap_evt, 1), 64'd2);
    reset = 1'b1;
    #1;
    check("async_reset_valid", 64'(snap_valid), 64'd0);
    check("async_reset_evt_ch1", ch44(snap_evt, 1), 64'd0);
    step(2);
    reset = 1'b0;

    // 8-bit counters: reach 250, then add 10
    enable8 = 1'b1;
    evt8 = 16'h000F;
    step(16);
    evt8 = 16'h000A;
    step(1);
    evt8 = '0;
    check("ovf8_before", 64'({ovf_w, ovf_s}), 64'd0);
    snap_req8 = 1'b1; step(1); snap_req8 = 1'b0;
    check("wrap_250", 64'(evt_w), 64'd250);
    check("sat_250", 64'(evt_s), 64'd250);
    snap_ready8 = 1'b1; step(1); snap_ready8 = 1'b0;
    evt8 = 16'h000A;
    step(1);
    evt8 = '0;
    check("wrap_ovf", 64'(ovf_w), 64'd1);
    check("sat_ovf", 64'(ovf_s), 64'd1);
    snap_req8 = 1'b1; step(1); snap_req8 = 1'b0;
    check("snap8_valid", 64'({valid_w, valid_s}), 64'd3);
    check("wrap_value", 64'(evt_w), 64'd4);
    check("sat_value", 64'(evt_s), 64'd255);
    check("lat8_zero", 64'({lat_w, lat_s}), 64'd0);
    check("pend8_zero", 64'({pend_w, pend_s}), 64'd0);
    snap_ready8 = 1'b1; step(1); snap_ready8 = 1'b0;
    clear8 = 1'b1; step(1); clear8 = 1'b0;
    check("ovf8_cleared", 64'({ovf_w, ovf_s}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
